sorted_pq: RTL and testbench

SORTED_PQ -- requirements
Module: sorted_pq

---
 rtl/sorted_pq_if.sv | 40 ++++
 rtl/sorted_pq.sv | 162 ++++++++++++++++
 tb/tb_sorted_pq.sv | 207 ++++++++++++++++++++
 3 files changed

// File: rtl/sorted_pq_if.sv
// sorted_pq_if -- request/status bundle for the sorted priority queue.
//
// Signals:
//   enq    insert request (driven by the user)
//   deq    remove-head request (driven by the user)
//   din    key to insert, sampled together with enq
//   dout   current head key, i.e. the smallest stored key (0 when empty)
//   busy   an operation is in progress; requests are ignored
//   full   all DEPTH entries are occupied
//   empty  no entries are stored
//   count  number of stored entries
//   err    sticky flag: an enq while full or a deq while empty was seen
//
// Modports: master = queue user, slave = the queue itself.
interface sorted_pq_if #(
    parameter int DEPTH = 16,
    parameter int KW    = 8
);
    localparam int CW = $clog2(DEPTH + 1);

    logic          enq;
    logic          deq;
    logic [KW-1:0] din;
    logic [KW-1:0] dout;
    logic          busy;
    logic          full;
    logic          empty;
    logic [CW-1:0] count;
    logic          err;

    modport master (
        output enq, deq, din,
        input  dout, busy, full, empty, count, err
    );

    modport slave (
        input  enq, deq, din,
        output dout, busy, full, empty, count, err
    );
endinterface

// File: rtl/sorted_pq.sv
// sorted_pq -- register-based priority queue that keeps DEPTH keys sorted
// ascending, with entry 0 as the head. Each accepted request spends exactly
// one cycle in a working state, so results appear two cycles after the
// request is sampled and a new request can be taken right after that.
//
// Ports:
//   clk   clock; all state changes on its rising edge
//   rst   synchronous, active-high reset; aborts any operation in flight
//   bus   sorted_pq_if.slave: enq/deq/din requests in; dout, busy, full,
//         empty, count and err out
module sorted_pq #(
    parameter int DEPTH = 16,
    parameter int KW    = 8
) (
    input  logic        clk,
    input  logic        rst,
    sorted_pq_if.slave  bus
);
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        INSERT,
        REMOVE,
        REPLACE
    } state_t;

    state_t        state_q, state_d;
    logic [KW-1:0] key_q, key_d;
    logic [KW-1:0] ent_q [DEPTH];
    logic [KW-1:0] ent_d [DEPTH];
    logic [CW-1:0] count_q, count_d;
    logic          err_q, err_d;

    logic          full;
    logic          empty;

    // Insertion network, shared by INSERT and REPLACE. For REPLACE the head
    // is dropped first (base is the array shifted down by one) and the key
    // is then inserted into the remaining count-1 entries.
    logic [KW-1:0]    base [DEPTH];
    logic [CW-1:0]    base_n;
    logic [DEPTH-1:0] le;
    logic [KW-1:0]    ins [DEPTH];

    assign full  = (count_q == CW'(DEPTH));
    assign empty = (count_q == '0);

    // NOTE: every signal written in a combinational block is given a value
    // on every path (here, first thing in the block); otherwise a latch is
    // inferred.
    always_comb begin
        for (int i = 0; i < DEPTH - 1; i++) begin
            base[i] = (state_q == REPLACE) ? ent_q[i + 1] : ent_q[i];
        end
        base[DEPTH-1] = (state_q == REPLACE) ? '0 : ent_q[DEPTH-1];
        base_n = (state_q == REPLACE) ? (count_q - CW'(1)) : count_q;

        // le is a prefix mask over the valid entries: "this entry stays put".
        // Using <= places the new key after equal keys, so ties stay FIFO.
        for (int i = 0; i < DEPTH; i++) begin
            le[i] = (CW'(i) < base_n) && (base[i] <= key_q);
        end

        // Slot at the end of the prefix takes the key; slots above it take
        // their lower neighbour. Unused slots hold 0, so zeros shift in.
        ins[0] = le[0] ? base[0] : key_q;
        for (int i = 1; i < DEPTH; i++) begin
            if (le[i]) begin
                ins[i] = base[i];
            end else if (le[i-1]) begin
                ins[i] = key_q;
            end else begin
                ins[i] = base[i-1];
            end
        end
    end

    // Next-state and datapath control.
    always_comb begin
        state_d = state_q;
        key_d   = key_q;
        ent_d   = ent_q;
        count_d = count_q;
        err_d   = err_q;

        case (state_q)
            IDLE: begin
                if (bus.enq && bus.deq && !empty) begin
                    key_d   = bus.din;
                    state_d = REPLACE;
                end else if (bus.enq) begin
                    // enq+deq on an empty queue falls through here as a plain insert.
                    if (!full) begin
                        key_d   = bus.din;
                        state_d = INSERT;
                    end else begin
                        err_d = 1'b1;
                    end
                end else if (bus.deq) begin
                    if (!empty) begin
                        state_d = REMOVE;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end

            INSERT: begin
                ent_d   = ins;
                count_d = count_q + CW'(1);
                state_d = IDLE;
            end

            REMOVE: begin
                for (int i = 0; i < DEPTH - 1; i++) begin
                    ent_d[i] = ent_q[i + 1];
                end
                ent_d[DEPTH-1] = '0;
                count_d = count_q - CW'(1);
                state_d = IDLE;
            end

            REPLACE: begin
                ent_d   = ins;
                state_d = IDLE;
            end

            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state is assigned with non-blocking (<=) so every flop
    // samples its pre-edge inputs regardless of statement order.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            key_q   <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
            // NOTE: the entry array is reset on purpose: the insertion network
            // relies on unused slots holding 0, and dout must read 0 after reset.
            for (int i = 0; i < DEPTH; i++) begin
                ent_q[i] <= '0;
            end
        end else begin
            state_q <= state_d;
            key_q   <= key_d;
            count_q <= count_d;
            err_q   <= err_d;
            ent_q   <= ent_d;
        end
    end

    assign bus.dout  = empty ? '0 : ent_q[0];
    assign bus.busy  = (state_q != IDLE);
    assign bus.full  = full;
    assign bus.empty = empty;
    assign bus.count = count_q;
    assign bus.err   = err_q;

endmodule

// File: tb/tb_sorted_pq.sv
// tb_sorted_pq -- directed, table-driven bench for sorted_pq (DEPTH=16, KW=8).
module tb_sorted_pq;
    localparam int DEPTH = 16;
    localparam int KW    = 8;

    typedef enum logic [1:0] {OP_RST, OP_ENQ, OP_DEQ, OP_REP} op_e;

    typedef struct {
        op_e      op;
        logic [7:0] key;
        logic [7:0] dout;
        logic [4:0] cnt;
        logic       err;
        logic       mid_busy;
    } vec_t;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    logic mid_busy;
    vec_t vecs [$];

    sorted_pq_if #(.DEPTH(DEPTH), .KW(KW)) bus ();

    sorted_pq #(.DEPTH(DEPTH), .KW(KW)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Advance past the next rising edge; sampling and driving happen here.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present one request for a single cycle, record busy in the working
    // cycle, and return once the result is visible.
    task automatic apply(input op_e op, input logic [7:0] key);
        mid_busy = 1'b0;
        if (op == OP_RST) begin
            rst = 1'b1;
            tick();
            rst = 1'b0;
        end else begin
            bus.enq = (op == OP_ENQ) || (op == OP_REP);
            bus.deq = (op == OP_DEQ) || (op == OP_REP);
            bus.din = key;
            tick();
            bus.enq  = 1'b0;
            bus.deq  = 1'b0;
            mid_busy = bus.busy;
            tick();
        end
    endtask

    task automatic add(input op_e op, input int key, input int dout, input int cnt,
                       input bit err, input bit mb);
        vec_t v;
        v.op       = op;
        v.key      = 8'(key);
        v.dout     = 8'(dout);
        v.cnt      = 5'(cnt);
        v.err      = err;
        v.mid_busy = mb;
        vecs.push_back(v);
    endtask

    initial begin
        total   = 0;
        bad     = 0;
        rst     = 1'b1;
        bus.enq = 1'b0;
        bus.deq = 1'b0;
        bus.din = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state.
        check("rst_dout",  32'(bus.dout),  0);
        check("rst_count", 32'(bus.count), 0);
        check("rst_empty", 32'(bus.empty), 1);
        check("rst_full",  32'(bus.full),  0);
        check("rst_busy",  32'(bus.busy),  0);
        check("rst_err",   32'(bus.err),   0);

        // op, key, expected dout, count, err, busy during working cycle
        add(OP_ENQ, 5, 5, 1, 0, 1);
        add(OP_ENQ, 3, 3, 2, 0, 1);
        add(OP_ENQ, 9, 3, 3, 0, 1);
        add(OP_ENQ, 3, 3, 4, 0, 1);
        add(OP_DEQ, 0, 3, 3, 0, 1);
        add(OP_DEQ, 0, 5, 2, 0, 1);
        add(OP_DEQ, 0, 9, 1, 0, 1);
        add(OP_DEQ, 0, 0, 0, 0, 1);
        add(OP_DEQ, 0, 0, 0, 1, 0);  // deq on empty: error, no busy
        add(OP_ENQ, 7, 7, 1, 1, 1);  // still works, err sticky
        add(OP_RST, 0, 0, 0, 0, 0);
        add(OP_REP, 8, 8, 1, 0, 1);  // enq+deq on empty acts as insert
        add(OP_DEQ, 0, 0, 0, 0, 1);
        add(OP_ENQ, 2, 2, 1, 0, 1);
        add(OP_ENQ, 4, 2, 2, 0, 1);
        add(OP_ENQ, 6, 2, 3, 0, 1);
        add(OP_REP, 5, 4, 3, 0, 1);  // {2,4,6} -> {4,5,6}
        add(OP_DEQ, 0, 5, 2, 0, 1);
        add(OP_DEQ, 0, 6, 1, 0, 1);
        add(OP_REP, 1, 1, 1, 0, 1);  // {6} -> {1}
        add(OP_ENQ, 9, 1, 2, 0, 1);
        add(OP_REP, 0, 0, 2, 0, 1);  // {1,9} -> {0,9}; dout 0 while not empty
        add(OP_DEQ, 0, 9, 1, 0, 1);
        add(OP_REP, 9, 9, 1, 0, 1);  // equal key
        add(OP_DEQ, 0, 0, 0, 0, 1);

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i].op, vecs[i].key);
            check($sformatf("v%0d_dout", i),  32'(bus.dout),  32'(vecs[i].dout));
            check($sformatf("v%0d_count", i), 32'(bus.count), 32'(vecs[i].cnt));
            check($sformatf("v%0d_err", i),   32'(bus.err),   32'(vecs[i].err));
            check($sformatf("v%0d_empty", i), 32'(bus.empty), 32'(vecs[i].cnt == 0));
            check($sformatf("v%0d_busy", i),  32'(bus.busy),  0);
            if (vecs[i].op != OP_RST) begin
                check($sformatf("v%0d_midbusy", i), 32'(mid_busy), 32'(vecs[i].mid_busy));
            end
        end

        // Fill with 15..0, replace at full, then overflow.
        apply(OP_RST, 0);
        for (int k = 15; k >= 0; k--) begin
            apply(OP_ENQ, 8'(k));
            check("fill_count", 32'(bus.count), 32'(16 - k));
            check("fill_full",  32'(bus.full),  32'(k == 0));
        end
        check("fill_dout", 32'(bus.dout), 0);
        check("fill_err",  32'(bus.err),  0);
        apply(OP_REP, 8'd20);
        check("fullrep_dout",  32'(bus.dout),  1);
        check("fullrep_count", 32'(bus.count), 16);
        check("fullrep_full",  32'(bus.full),  1);
        apply(OP_ENQ, 8'd100);
        check("ovf_err",   32'(bus.err),   1);
        check("ovf_busy",  32'(mid_busy),  0);
        check("ovf_count", 32'(bus.count), 16);
        check("ovf_dout",  32'(bus.dout),  1);
        for (int k = 1; k <= 15; k++) begin
            check("drain_dout", 32'(bus.dout), 32'(k));
            apply(OP_DEQ, 0);
        end
        check("drain_last", 32'(bus.dout), 20);
        apply(OP_DEQ, 0);
        check("drain_empty", 32'(bus.empty), 1);
        check("drain_dout0", 32'(bus.dout),  0);

        // enq held through the busy cycle with a different key: only the
        // first request is taken.
        apply(OP_RST, 0);
        bus.enq = 1'b1;
        bus.din = 8'd1;
        tick();
        bus.din = 8'd2;
        check("hold_busy", 32'(bus.busy), 1);
        tick();
        bus.enq = 1'b0;
        bus.din = 8'd0;
        check("hold_count", 32'(bus.count), 1);
        check("hold_dout",  32'(bus.dout),  1);
        check("hold_err",   32'(bus.err),   0);
        tick();
        check("hold_idle_count", 32'(bus.count), 1);
        check("hold_idle_busy",  32'(bus.busy),  0);

        // Reset during a REMOVE.
        apply(OP_RST, 0);
        apply(OP_ENQ, 8'd1);
        apply(OP_ENQ, 8'd2);
        check("abort_pre_count", 32'(bus.count), 2);
        bus.deq = 1'b1;
        tick();
        bus.deq = 1'b0;
        check("abort_busy", 32'(bus.busy), 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("abort_count", 32'(bus.count), 0);
        check("abort_empty", 32'(bus.empty), 1);
        check("abort_busyq", 32'(bus.busy),  0);
        check("abort_err",   32'(bus.err),   0);
        check("abort_dout",  32'(bus.dout),  0);
        tick();
        check("abort_stay_count", 32'(bus.count), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
